// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: funct3 width codes,
// FSM state encoding and small helpers for store lane replication and
// misalignment detection.
package data_mem_ctrl_pkg;

  // Load width codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store width codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Replicate the LSB-justified store value across all byte lanes so the
  // byte enables alone pick the destination lane.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] sd);
    case (f3[1:0])
      2'b00:   return {4{sd[7:0]}};
      2'b01:   return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

  // Halves need addr[0]==0, words need addr[1:0]==0; bytes are always aligned.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Data-memory bus: request channel (valid/ready) plus read-data return.
// master = controller side, slave = memory side.
interface data_mem_ctrl_if #(parameter int ADDR_W = 32) ();
  logic              bus_valid;
  logic              bus_ready;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_wstrb;
  logic [31:0]       bus_wdata;
  logic              bus_rvalid;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/data_mem_ctrl_load_align.sv
// Combinational load alignment: picks the addressed byte/half out of the
// read word and sign- or zero-extends it according to funct3.
module load_align
  import data_mem_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lo,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign half_sel = lo[1] ? rdata[31:16] : rdata[15:0];

  // Byte lane select by low address bits
  always_comb begin
    byte_sel = rdata[7:0];
    case (lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
  end

  // Width/extension select
  always_comb begin
    result = rdata;
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  result = {24'd0, byte_sel};
      F3_LHU:  result = {16'd0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: runs one decoded load/store on the valid/ready
// data bus, aligns load data for write-back and stalls the pipe while busy.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned halves/words complete
// immediately with rsp_err instead of going to the bus).
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       store_data,
  input  logic [3:0]        wstrobe,
  input  logic              wen,
  input  logic              ren,
  data_mem_ctrl_if.master   bus,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic              stall
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t            state, state_nxt;
  logic              accept, trap, expired;
  logic              cap, tmo, cnt_clr, cnt_inc;
  logic [CW-1:0]     cnt;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        lo_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       wdata_q;
  logic [31:0]       aligned;

  assign accept = (state == ST_IDLE) && req_valid && (wen || ren);

`ifdef MISALIGN_TRAP_EN
  assign trap = misaligned(funct3, address[1:0]);
`else
  assign trap = 1'b0;
`endif

  // Waiting budget is TIMEOUT_CYC cycles; 0 disables the abort entirely.
  assign expired = (TIMEOUT_CYC != 0) && (cnt == CW'(TIMEOUT_CYC - 1));

  assign req_ready     = (state == ST_IDLE);
  assign stall         = (state == ST_REQ) || (state == ST_WAIT_R) || accept;
  assign rsp_valid     = (state == ST_RESP);
  assign bus.bus_valid = (state == ST_REQ);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wstrb = wstrb_q;
  assign bus.bus_wdata = wdata_q;

  load_align u_align (
    .funct3 (f3_q),
    .lo     (lo_q),
    .rdata  (bus.bus_rdata),
    .result (aligned)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    tmo       = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = trap ? ST_RESP : ST_REQ;
          cnt_clr   = 1'b1;
        end
      end
      ST_REQ: begin
        if (bus.bus_ready) begin
          if (we_q) begin
            state_nxt = ST_RESP;
          end else if (bus.bus_rvalid) begin
            state_nxt = ST_RESP;
            cap       = 1'b1;
          end else begin
            state_nxt = ST_WAIT_R;
            cnt_clr   = 1'b1;
          end
        end else if (expired) begin
          state_nxt = ST_RESP;
          tmo       = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_WAIT_R: begin
        if (bus.bus_rvalid) begin
          state_nxt = ST_RESP;
          cap       = 1'b1;
        end else if (expired) begin
          state_nxt = ST_RESP;
          tmo       = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Wait-cycle counter for the bus timeout
  always_ff @(posedge clk) begin
    if (!resetn)      cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else if (cnt_inc) cnt <= cnt + CW'(1);
  end

  // Bus fields latched at accept and held until the next request; response
  // data/error set at accept, capture or timeout.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      we_q     <= 1'b0;
      f3_q     <= 3'd0;
      lo_q     <= 2'd0;
      addr_q   <= '0;
      wstrb_q  <= 4'd0;
      wdata_q  <= 32'd0;
      rsp_data <= 32'd0;
      rsp_err  <= 1'b0;
    end else begin
      if (accept) begin
        we_q     <= wen;
        f3_q     <= funct3;
        lo_q     <= address[1:0];
        addr_q   <= {address[ADDR_W-1:2], 2'b00};
        wstrb_q  <= wstrobe;
        wdata_q  <= wen ? store_lanes(funct3, store_data) : 32'd0;
        rsp_data <= 32'd0;
        rsp_err  <= trap;
      end
      if (cap) rsp_data <= aligned;
      if (tmo) begin
        rsp_data <= 32'd0;
        rsp_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: inputs change just after the falling
// edge, outputs are sampled 1 time unit later, away from the rising edge.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready, wen, ren;
  logic [2:0]  funct3;
  logic [31:0] address, store_data, rsp_data;
  logic [3:0]  wstrobe;
  logic        rsp_valid, rsp_err, stall;
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  data_mem_ctrl_if #(.ADDR_W(32)) bus ();

  data_mem_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .funct3(funct3), .address(address), .store_data(store_data), .wstrobe(wstrobe),
    .wen(wen), .ren(ren), .bus(bus), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .stall(stall)
  );

  task automatic set_req(input logic [2:0] f, input logic [31:0] a, input logic [31:0] sd,
                         input logic [3:0] s, input logic w, input logic r);
    req_valid = 1'b1; funct3 = f; address = a; store_data = sd; wstrobe = s; wen = w; ren = r;
  endtask

  // Load with rvalid alongside ready; returns at the RESP cycle (sampled).
  task automatic run_fast_load(input logic [2:0] f, input logic [31:0] a,
                               input logic [3:0] s, input logic [31:0] rd);
    repeat (2) @(negedge clk);
    set_req(f, a, 32'd0, s, 1'b0, 1'b1);
    bus.bus_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; bus.bus_rvalid = 1'b1; bus.bus_rdata = rd;
    @(negedge clk);
    bus.bus_rvalid = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0; req_valid = 1'b0; wen = 1'b0; ren = 1'b0; funct3 = 3'd0;
    address = 32'd0; store_data = 32'd0; wstrobe = 4'd0;
    bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({bus.bus_valid, bus.bus_we, rsp_valid, rsp_err} !== 4'b0000)
      $display("FAIL rst_ctrl got=%b exp=0000", {bus.bus_valid, bus.bus_we, rsp_valid, rsp_err});
    else passed++;
    total++;
    if ({bus.bus_addr, bus.bus_wstrb, bus.bus_wdata, rsp_data} !== 100'd0)
      $display("FAIL rst_data got=%h exp=0", {bus.bus_addr, bus.bus_wstrb, bus.bus_wdata, rsp_data});
    else passed++;
    total++;
    if ({req_ready, stall} !== 2'b10) $display("FAIL rst_ready got=%b exp=10", {req_ready, stall});
    else passed++;
    resetn = 1'b1;
  endtask

  task automatic test_store_word;
    repeat (2) @(negedge clk);
    set_req(F3_SW, 32'h100, 32'hDEADBEEF, 4'b1111, 1'b1, 1'b0);
    bus.bus_ready = 1'b1;
    #1;
    total++;
    if ({req_ready, stall} !== 2'b11) $display("FAIL sw_accept got=%b exp=11", {req_ready, stall});
    else passed++;
    @(negedge clk); req_valid = 1'b0; #1;
    total++;
    if ({bus.bus_valid, bus.bus_we, rsp_valid} !== 3'b110)
      $display("FAIL sw_req_ctrl got=%b exp=110", {bus.bus_valid, bus.bus_we, rsp_valid});
    else passed++;
    total++;
    if ({bus.bus_addr, bus.bus_wstrb, bus.bus_wdata} !== {32'h100, 4'b1111, 32'hDEADBEEF})
      $display("FAIL sw_req_fields got=%h/%b/%h exp=100/1111/deadbeef", bus.bus_addr, bus.bus_wstrb, bus.bus_wdata);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({rsp_valid, rsp_err, stall, req_ready, rsp_data} !== {4'b1000, 32'd0})
      $display("FAIL sw_resp got=%b data=%h exp=1000 data=0", {rsp_valid, rsp_err, stall, req_ready}, rsp_data);
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({rsp_valid, req_ready} !== 2'b01) $display("FAIL sw_idle got=%b exp=01", {rsp_valid, req_ready});
    else passed++;
  endtask

  task automatic test_load_byte;
    repeat (2) @(negedge clk);
    set_req(F3_LB, 32'h103, 32'd0, 4'b1000, 1'b0, 1'b1);
    bus.bus_ready = 1'b1; bus.bus_rvalid = 1'b0;
    @(negedge clk); req_valid = 1'b0; #1;
    total++;
    if ({bus.bus_valid, bus.bus_we, bus.bus_addr, bus.bus_wstrb} !== {2'b10, 32'h100, 4'b1000})
      $display("FAIL lb_req got=%b/%h/%b exp=10/100/1000", {bus.bus_valid, bus.bus_we}, bus.bus_addr, bus.bus_wstrb);
    else passed++;
    @(negedge clk); bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'h80123456; #1;
    total++;
    if ({bus.bus_valid, stall, rsp_valid} !== 3'b010)
      $display("FAIL lb_wait got=%b exp=010", {bus.bus_valid, stall, rsp_valid});
    else passed++;
    @(negedge clk); bus.bus_rvalid = 1'b0; #1;
    total++;
    if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 32'hFFFFFF80})
      $display("FAIL lb_resp got=%b data=%h exp=10 data=ffffff80", {rsp_valid, rsp_err}, rsp_data);
    else passed++;
    run_fast_load(F3_LBU, 32'h103, 4'b1000, 32'h80ABCDEF);
    total++;
    if ({rsp_valid, rsp_data} !== {1'b1, 32'h00000080})
      $display("FAIL lbu_resp got=%b data=%h exp=1 data=00000080", rsp_valid, rsp_data);
    else passed++;
  endtask

  task automatic test_load_half;
    repeat (2) @(negedge clk);
    set_req(F3_LHU, 32'h202, 32'd0, 4'b1100, 1'b0, 1'b1);
    bus.bus_ready = 1'b1;
    @(negedge clk); req_valid = 1'b0; bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'hBEEF1234; #1;
    total++;
    if ({bus.bus_valid, bus.bus_addr, bus.bus_wstrb} !== {1'b1, 32'h200, 4'b1100})
      $display("FAIL lhu_req got=%b/%h/%b exp=1/200/1100", bus.bus_valid, bus.bus_addr, bus.bus_wstrb);
    else passed++;
    @(negedge clk); bus.bus_rvalid = 1'b0; #1;
    total++;
    if ({rsp_valid, rsp_data} !== {1'b1, 32'h0000BEEF})
      $display("FAIL lhu_resp got=%b data=%h exp=1 data=0000beef", rsp_valid, rsp_data);
    else passed++;
    run_fast_load(F3_LH, 32'h200, 4'b0011, 32'h12348001);
    total++;
    if ({rsp_valid, rsp_data} !== {1'b1, 32'hFFFF8001})
      $display("FAIL lh_resp got=%b data=%h exp=1 data=ffff8001", rsp_valid, rsp_data);
    else passed++;
    run_fast_load(F3_LW, 32'h104, 4'b1111, 32'h89ABCDEF);
    total++;
    if ({rsp_valid, rsp_data} !== {1'b1, 32'h89ABCDEF})
      $display("FAIL lw_resp got=%b data=%h exp=1 data=89abcdef", rsp_valid, rsp_data);
    else passed++;
  endtask

  task automatic test_store_stall;
    repeat (2) @(negedge clk);
    set_req(F3_SB, 32'h301, 32'hFFFF12AB, 4'b0010, 1'b1, 1'b0);
    bus.bus_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); req_valid = 1'b0; #1;
      total++;
      if ({bus.bus_valid, stall, rsp_valid, bus.bus_addr, bus.bus_wstrb, bus.bus_wdata}
          !== {3'b110, 32'h300, 4'b0010, 32'hABABABAB})
        $display("FAIL sb_hold%0d got=%b/%h/%b/%h exp=110/300/0010/abababab", i,
                 {bus.bus_valid, stall, rsp_valid}, bus.bus_addr, bus.bus_wstrb, bus.bus_wdata);
      else passed++;
    end
    @(negedge clk); bus.bus_ready = 1'b1;
    @(negedge clk); #1;
    total++;
    if ({rsp_valid, rsp_err, stall} !== 3'b100)
      $display("FAIL sb_resp got=%b exp=100", {rsp_valid, rsp_err, stall});
    else passed++;
    repeat (2) @(negedge clk);
    set_req(F3_SH, 32'h202, 32'h0000CAFE, 4'b1100, 1'b1, 1'b0);
    @(negedge clk); req_valid = 1'b0; #1;
    total++;
    if ({bus.bus_wdata, bus.bus_wstrb, bus.bus_addr} !== {32'hCAFECAFE, 4'b1100, 32'h200})
      $display("FAIL sh_req got=%h/%b/%h exp=cafecafe/1100/200", bus.bus_wdata, bus.bus_wstrb, bus.bus_addr);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int n;
    // Read data never returns
    repeat (2) @(negedge clk);
    set_req(F3_LW, 32'h10C, 32'd0, 4'b1111, 1'b0, 1'b1);
    bus.bus_ready = 1'b1; bus.bus_rvalid = 1'b0;
    @(negedge clk); req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!rsp_valid && n < 50);
    total++;
    if (n !== TMO + 1) $display("FAIL rd_tmo_cycles got=%0d exp=%0d", n, TMO + 1);
    else passed++;
    total++;
    if ({rsp_valid, rsp_err, bus.bus_valid, rsp_data} !== {3'b110, 32'd0})
      $display("FAIL rd_tmo_rsp got=%b data=%h exp=110 data=0", {rsp_valid, rsp_err, bus.bus_valid}, rsp_data);
    else passed++;
    // Bus never accepts
    repeat (2) @(negedge clk);
    set_req(F3_SW, 32'h110, 32'h55AA55AA, 4'b1111, 1'b1, 1'b0);
    bus.bus_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk); req_valid = 1'b0; #1; n++;
    end while (!rsp_valid && n < 50);
    total++;
    if (n !== TMO + 1) $display("FAIL req_tmo_cycles got=%0d exp=%0d", n, TMO + 1);
    else passed++;
    total++;
    if ({rsp_valid, rsp_err, bus.bus_valid, stall} !== 4'b1100)
      $display("FAIL req_tmo_rsp got=%b exp=1100", {rsp_valid, rsp_err, bus.bus_valid, stall});
    else passed++;
  endtask

  task automatic test_reset_mid;
    repeat (2) @(negedge clk);
    set_req(F3_LW, 32'h120, 32'd0, 4'b1111, 1'b0, 1'b1);
    bus.bus_ready = 1'b1; bus.bus_rvalid = 1'b0;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); #1;
    total++;
    if ({stall, bus.bus_valid} !== 2'b10) $display("FAIL rm_wait got=%b exp=10", {stall, bus.bus_valid});
    else passed++;
    resetn = 1'b0;
    @(negedge clk); #1;
    total++;
    if ({req_ready, bus.bus_valid, rsp_valid, stall} !== 4'b1000)
      $display("FAIL rm_idle got=%b exp=1000", {req_ready, bus.bus_valid, rsp_valid, stall});
    else passed++;
    resetn = 1'b1; bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'hCAFEF00D;
    @(negedge clk); #1;
    total++;
    if ({rsp_valid, req_ready, stall, rsp_data} !== {3'b010, 32'd0})
      $display("FAIL rm_stray got=%b data=%h exp=010 data=0", {rsp_valid, req_ready, stall}, rsp_data);
    else passed++;
    @(negedge clk); bus.bus_rvalid = 1'b0; #1;
    total++;
    if (rsp_valid !== 1'b0) $display("FAIL rm_stray2 got=%b exp=0", rsp_valid);
    else passed++;
  endtask

  task automatic test_ignored;
    repeat (2) @(negedge clk);
    set_req(F3_LW, 32'h130, 32'd0, 4'b1111, 1'b0, 1'b0);
    #1;
    total++;
    if ({req_ready, stall} !== 2'b10) $display("FAIL ign_accept got=%b exp=10", {req_ready, stall});
    else passed++;
    @(negedge clk); req_valid = 1'b0; #1;
    total++;
    if ({bus.bus_valid, req_ready, stall, rsp_valid} !== 4'b0100)
      $display("FAIL ign_idle got=%b exp=0100", {bus.bus_valid, req_ready, stall, rsp_valid});
    else passed++;
  endtask

  task automatic test_misalign;
    repeat (2) @(negedge clk);
    set_req(F3_LW, 32'h102, 32'd0, 4'b1111, 1'b0, 1'b1);
    bus.bus_ready = 1'b1; bus.bus_rvalid = 1'b0;
`ifdef MISALIGN_TRAP_EN
    #1;
    total++;
    if (stall !== 1'b1) $display("FAIL mis_accept got=%b exp=1", stall);
    else passed++;
    @(negedge clk); req_valid = 1'b0; #1;
    total++;
    if ({bus.bus_valid, rsp_valid, rsp_err, rsp_data} !== {3'b011, 32'd0})
      $display("FAIL mis_trap got=%b data=%h exp=011 data=0", {bus.bus_valid, rsp_valid, rsp_err}, rsp_data);
    else passed++;
`else
    @(negedge clk); req_valid = 1'b0; bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'h11223344; #1;
    total++;
    if ({bus.bus_valid, bus.bus_addr} !== {1'b1, 32'h100})
      $display("FAIL mis_req got=%b/%h exp=1/100", bus.bus_valid, bus.bus_addr);
    else passed++;
    @(negedge clk); bus.bus_rvalid = 1'b0; #1;
    total++;
    if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 32'h11223344})
      $display("FAIL mis_resp got=%b data=%h exp=10 data=11223344", {rsp_valid, rsp_err}, rsp_data);
    else passed++;
`endif
  endtask

  task automatic test_back_to_back;
    logic [5:0] rsp_pat, rdy_pat;
    repeat (2) @(negedge clk);
    bus.bus_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      set_req(F3_SW, 32'h400 + 32'(c), 32'(c), 4'b1111, 1'b1, 1'b0);
      #1;
      rsp_pat[c] = rsp_valid;
      rdy_pat[c] = req_ready;
      @(negedge clk);
    end
    req_valid = 1'b0;
    total++;
    if (rsp_pat !== 6'b100100) $display("FAIL b2b_rsp got=%b exp=100100", rsp_pat);
    else passed++;
    total++;
    if (rdy_pat !== 6'b001001) $display("FAIL b2b_ready got=%b exp=001001", rdy_pat);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_load_half();
    test_store_stall();
    test_timeout();
    test_reset_mid();
    test_ignored();
    test_misalign();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
